anpc_level_sched: RTL and testbench

Command scheduler for one three-level ANPC leg commutation FSM. Converts a requested output level (zero/P/N) into the `v_lev`/`comm_type` command pair for the leg FSM. Holds each command for a programmable lockout so the FSM finishes its dead-time sequence before the next command arrives. Routes P↔N requests through zero, and selects or rotates the zero-state commutation type for loss balancing.

---
 rtl/anpc_level_sched.sv | 131 +++++++++++++
 tb/tb_anpc_level_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/anpc_level_sched.sv
// rtl/anpc_level_sched.sv - level command scheduler for a three-level ANPC leg FSM
module anpc_level_sched #(
    parameter int LOCK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              en,
    input  logic [1:0]        lev_req,
    input  logic [1:0]        mode,
    input  logic [LOCK_W-1:0] t_lock,
    input  logic [LOCK_W-1:0] t_dwell_zero,
    output logic [1:0]        v_lev,
    output logic [1:0]        comm_type,
    output logic              busy,
    output logic              err_req,
    output logic [LOCK_W-1:0] cmd_cnt
);

    typedef enum logic {
        READY = 1'b0,
        LOCK  = 1'b1
    } state_t;

    localparam logic [1:0] LEV_ZERO = 2'd0;
    localparam logic [1:0] LEV_BAD  = 2'd3;

    state_t            state;
    state_t            state_nxt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_nxt;
    logic [LOCK_W-1:0] cmd_cnt_nxt;
    logic [1:0]        v_lev_nxt;
    logic [1:0]        comm_nxt;
    logic [1:0]        rot_idx;
    logic [1:0]        rot_nxt;
    logic              err_nxt;

    logic [1:0]        tgt;
    logic [LOCK_W-1:0] lock_min;
    logic [LOCK_W-1:0] lock_zero;
    logic [1:0]        rot_type;
    logic [1:0]        sel_type;

    // Target level, lockout lengths and the commutation type chosen for a move into zero
    always_comb begin
        tgt       = en ? lev_req : LEV_ZERO;
        lock_min  = (t_lock == '0) ? LOCK_W'(1) : t_lock;
        lock_zero = (t_dwell_zero > lock_min) ? t_dwell_zero : lock_min;
        case (rot_idx)
            2'd0:    rot_type = 2'd0;
            2'd1:    rot_type = 2'd2;
            default: rot_type = 2'd3;
        endcase
        case (mode)
            2'd0:    sel_type = 2'd0;
            2'd1:    sel_type = 2'd2;
            2'd2:    sel_type = 2'd3;
            default: sel_type = rot_type;
        endcase
    end

    // Next-state and command decisions; P<->N requests are split so only zero is issued now
    always_comb begin
        state_nxt   = state;
        lock_nxt    = lock_cnt;
        cmd_cnt_nxt = cmd_cnt;
        v_lev_nxt   = v_lev;
        comm_nxt    = comm_type;
        rot_nxt     = rot_idx;
        err_nxt     = 1'b0;
        case (state)
            READY: begin
                if (en && lev_req == LEV_BAD) begin
                    err_nxt = 1'b1;
                end else if (tgt != v_lev) begin
                    cmd_cnt_nxt = cmd_cnt + LOCK_W'(1);
                    state_nxt   = LOCK;
                    if (tgt == LEV_ZERO || v_lev == LEV_ZERO) begin
                        v_lev_nxt = tgt;
                        lock_nxt  = lock_min;
                    end else begin
                        v_lev_nxt = LEV_ZERO;
                        lock_nxt  = lock_zero;
                    end
                    // Only moves out of P or N into zero pick a new commutation type
                    if (v_lev != LEV_ZERO && v_lev_nxt == LEV_ZERO) begin
                        comm_nxt = sel_type;
                        if (mode == 2'd3) begin
                            rot_nxt = (rot_idx == 2'd2) ? 2'd0 : rot_idx + 2'd1;
                        end
                    end
                end
            end
            LOCK: begin
                lock_nxt = lock_cnt - LOCK_W'(1);
                if (lock_cnt == LOCK_W'(1)) begin
                    state_nxt = READY;
                end
            end
            default: begin
                state_nxt = READY;
                lock_nxt  = '0;
            end
        endcase
    end

    // State and output registers, advanced only on enabled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= READY;
            lock_cnt  <= '0;
            cmd_cnt   <= '0;
            v_lev     <= LEV_ZERO;
            comm_type <= 2'd0;
            rot_idx   <= 2'd0;
            err_req   <= 1'b0;
            busy      <= 1'b0;
        end else if (ce) begin
            state     <= state_nxt;
            lock_cnt  <= lock_nxt;
            cmd_cnt   <= cmd_cnt_nxt;
            v_lev     <= v_lev_nxt;
            comm_type <= comm_nxt;
            rot_idx   <= rot_nxt;
            err_req   <= err_nxt;
            busy      <= (state_nxt == LOCK);
        end
    end

endmodule

// File: tb/tb_anpc_level_sched.sv
// tb/tb_anpc_level_sched.sv - directed self-checking bench for anpc_level_sched
module tb_anpc_level_sched;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        en;
    logic [1:0]  lev_req;
    logic [1:0]  mode;
    logic [15:0] t_lock;
    logic [15:0] t_dwell_zero;
    logic [1:0]  v_lev;
    logic [1:0]  comm_type;
    logic        busy;
    logic        err_req;
    logic [15:0] cmd_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    anpc_level_sched #(.LOCK_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .en           (en),
        .lev_req      (lev_req),
        .mode         (mode),
        .t_lock       (t_lock),
        .t_dwell_zero (t_dwell_zero),
        .v_lev        (v_lev),
        .comm_type    (comm_type),
        .busy         (busy),
        .err_req      (err_req),
        .cmd_cnt      (cmd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b1; en = 1'b1; lev_req = 2'd1; mode = 2'd0;
        t_lock = 16'd10; t_dwell_zero = 16'd0;
        tick(); tick();
        checks++; if (v_lev !== 2'd0) begin errors++; $display("FAIL reset_v_lev got %0d exp 0", v_lev); end
        checks++; if (comm_type !== 2'd0) begin errors++; $display("FAIL reset_comm got %0d exp 0", comm_type); end
        checks++; if (busy !== 1'b0 || err_req !== 1'b0) begin errors++; $display("FAIL reset_flags got busy %0b err %0b exp 0 0", busy, err_req); end
        checks++; if (cmd_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cmd_cnt); end
        exp_cnt = 16'd0;
    endtask

    task automatic test_first_cmd();
        int n;
        rst = 1'b1;
        tick();
        exp_cnt++;
        checks++; if (v_lev !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL first_cmd got v_lev %0d busy %0b exp 1 1", v_lev, busy); end
        checks++; if (cmd_cnt !== exp_cnt) begin errors++; $display("FAIL first_cnt got %0d exp %0d", cmd_cnt, exp_cnt); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n != 10) begin errors++; $display("FAIL lock10_len got %0d exp 10", n); end
    endtask

    task automatic test_p_to_n();
        lev_req = 2'd2; t_lock = 16'd4; t_dwell_zero = 16'd20; mode = 2'd1;
        tick();
        exp_cnt++;
        checks++; if (v_lev !== 2'd0 || comm_type !== 2'd2) begin errors++; $display("FAIL pn_zero got v_lev %0d comm %0d exp 0 2", v_lev, comm_type); end
        t_lock = 16'd1; t_dwell_zero = 16'd1;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (v_lev !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL pn_dwell got v_lev %0d busy %0b exp 0 0", v_lev, busy); end
        t_lock = 16'd4;
        tick();
        exp_cnt++;
        checks++; if (v_lev !== 2'd2) begin errors++; $display("FAIL pn_final got %0d exp 2", v_lev); end
        checks++; if (cmd_cnt !== exp_cnt) begin errors++; $display("FAIL pn_cnt got %0d exp %0d", cmd_cnt, exp_cnt); end
    endtask

    task automatic test_err();
        int pulses;
        lev_req = 2'd3;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (err_req === 1'b1) pulses++; end
        checks++; if (pulses != 0 || busy !== 1'b0) begin errors++; $display("FAIL err_in_lock got pulses %0d busy %0b exp 0 0", pulses, busy); end
        tick();
        checks++; if (err_req !== 1'b1 || v_lev !== 2'd2) begin errors++; $display("FAIL err_pulse got err %0b v_lev %0d exp 1 2", err_req, v_lev); end
        lev_req = 2'd2;
        tick();
        checks++; if (err_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_clear got err %0b busy %0b exp 0 0", err_req, busy); end
    endtask

    task automatic test_rotate();
        logic [1:0] exp_seq [6];
        logic [1:0] prev;
        exp_seq = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        t_lock = 16'd1; t_dwell_zero = 16'd0; mode = 2'd0; lev_req = 2'd0;
        tick(); tick();
        exp_cnt++;
        prev = 2'd0;
        mode = 2'd3;
        for (int i = 0; i < 6; i++) begin
            lev_req = 2'd1;
            tick(); tick();
            exp_cnt++;
            checks++; if (v_lev !== 2'd1 || comm_type !== prev) begin errors++; $display("FAIL rot_hold%0d got v_lev %0d comm %0d exp 1 %0d", i, v_lev, comm_type, prev); end
            lev_req = 2'd0;
            tick();
            exp_cnt++;
            checks++; if (v_lev !== 2'd0 || comm_type !== exp_seq[i]) begin errors++; $display("FAIL rot_seq%0d got v_lev %0d comm %0d exp 0 %0d", i, v_lev, comm_type, exp_seq[i]); end
            prev = exp_seq[i];
            tick();
        end
        checks++; if (cmd_cnt !== exp_cnt) begin errors++; $display("FAIL rot_cnt got %0d exp %0d", cmd_cnt, exp_cnt); end
    endtask

    task automatic test_ce_gating();
        int n;
        int j;
        t_lock = 16'd5; lev_req = 2'd1; ce = 1'b1;
        tick();
        exp_cnt++;
        n = 0; j = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            ce = (j % 3 == 2);
            j++;
            tick();
        end
        checks++; if (n != 15) begin errors++; $display("FAIL ce_busy_len got %0d exp 15", n); end
        ce = 1'b0; lev_req = 2'd0;
        tick(); tick(); tick();
        checks++; if (v_lev !== 2'd1 || busy !== 1'b0 || cmd_cnt !== exp_cnt) begin errors++; $display("FAIL ce_hold got v_lev %0d busy %0b cnt %0d exp 1 0 %0d", v_lev, busy, cmd_cnt, exp_cnt); end
        ce = 1'b1; lev_req = 2'd1;
    endtask

    task automatic test_reset_mid_lock();
        int n;
        lev_req = 2'd2; mode = 2'd2; t_lock = 16'd10; t_dwell_zero = 16'd0;
        tick();
        checks++; if (v_lev !== 2'd0 || comm_type !== 2'd3) begin errors++; $display("FAIL pn2_zero got v_lev %0d comm %0d exp 0 3", v_lev, comm_type); end
        n = 0;
        while (v_lev !== 2'd2 && n < 40) begin n++; tick(); end
        checks++; if (n != 11) begin errors++; $display("FAIL pn2_wait got %0d exp 11", n); end
        tick(); tick(); tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (v_lev !== 2'd0 || comm_type !== 2'd0) begin errors++; $display("FAIL async_rst_lev got v_lev %0d comm %0d exp 0 0", v_lev, comm_type); end
        checks++; if (busy !== 1'b0 || cmd_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_flags got busy %0b cnt %0d exp 0 0", busy, cmd_cnt); end
    endtask

    task automatic test_lock_zero();
        tick();
        rst = 1'b1; lev_req = 2'd1; en = 1'b1; t_lock = 16'd0;
        tick();
        checks++; if (v_lev !== 2'd1 || busy !== 1'b1 || cmd_cnt !== 16'd1) begin errors++; $display("FAIL tl0_cmd got v_lev %0d busy %0b cnt %0d exp 1 1 1", v_lev, busy, cmd_cnt); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tl0_busy got %0b exp 0", busy); end
        en = 1'b0;
        tick();
        checks++; if (v_lev !== 2'd0 || cmd_cnt !== 16'd2) begin errors++; $display("FAIL en_off got v_lev %0d cnt %0d exp 0 2", v_lev, cmd_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_cmd();
        test_p_to_n();
        test_err();
        test_rotate();
        test_ce_gating();
        test_reset_mid_lock();
        test_lock_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
